// File: rtl/video_cga_pixel.sv
// CGA text-mode pixel back end: attribute colour, blink, cursor and RGBI->VGA map, 2-stage pipeline.
// Optional hardware cursor enabled by defining VIDEO_CGA_CURSOR_EN.
module video_cga_pixel #(
    parameter int BLINK_BIT  = 4,
    parameter int CURSOR_BIT = 3
) (
    input  logic        iClk25,
    input  logic        iRstN,
    input  logic [7:0]  iChar,
    input  logic [7:0]  iAttr,
    input  logic [7:0]  iGlyphRow,
    input  logic [3:0]  iDA,
    input  logic [2:0]  iRA,
    input  logic [11:0] iCellAddr,
    input  logic        iBlank,
    input  logic        iHs,
    input  logic        iVs,
    input  logic        iVideoEn,
    input  logic        iBlinkEn,
    input  logic [11:0] iCursorAddr,
    input  logic [2:0]  iCursorStart,
    input  logic [2:0]  iCursorEnd,
    output logic [3:0]  oVgaR,
    output logic [3:0]  oVgaG,
    output logic [3:0]  oVgaB,
    output logic        oVgaHs,
    output logic        oVgaVs
);

    // One RGBI channel: set bit gives A (or F when intense), clear bit gives 0 (or 5 when intense).
    function automatic logic [3:0] rgbiChan(input logic bitOn, input logic intense);
        logic [3:0] level;
        if (bitOn) begin
            level = intense ? 4'hF : 4'hA;
        end else begin
            level = intense ? 4'h5 : 4'h0;
        end
        return level;
    endfunction

    logic       vsPrevR;
    logic [4:0] frameCntR;
    logic       vsRise;

    logic [3:0] s1IdxR;
    logic       s1BlankR;
    logic       s1HsR;
    logic       s1VsR;

    logic [2:0] dotSel;
    logic       glyphDot;
    logic       blinkHide;
    logic       cursorHit;
    logic       dot;
    logic [3:0] fg;
    logic [3:0] bg;
    logic [3:0] idxNext;

    logic [3:0] rNext;
    logic [3:0] gNext;
    logic [3:0] bNext;

    logic unusedBits;
    assign unusedBits = ^{iChar, iDA[0], iCellAddr, iRA, iCursorAddr, iCursorStart, iCursorEnd, frameCntR};

    assign vsRise = iVs & ~vsPrevR;

    // Frame counter advancing on each vertical sync rising edge; wraps naturally at 5 bits.
    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            vsPrevR   <= 1'b0;
            frameCntR <= 5'd0;
        end else begin
            vsPrevR <= iVs;
            if (vsRise) begin
                frameCntR <= frameCntR + 5'd1;
            end else begin
                frameCntR <= frameCntR;
            end
        end
    end

    // Stage 1 colour-index selection; blink and cursor use the pre-increment counter.
    always_comb begin
        dotSel    = 3'd7 - iDA[3:1];
        glyphDot  = iGlyphRow[dotSel];
        fg        = iAttr[3:0];
        bg        = iBlinkEn ? {1'b0, iAttr[6:4]} : iAttr[7:4];
        blinkHide = iBlinkEn & iAttr[7] & frameCntR[BLINK_BIT];
`ifdef VIDEO_CGA_CURSOR_EN
        cursorHit = (iCellAddr == iCursorAddr) && (iRA >= iCursorStart) &&
                    (iRA <= iCursorEnd) && frameCntR[CURSOR_BIT];
`else
        cursorHit = 1'b0;
`endif
        if (cursorHit) begin
            dot = 1'b1;
        end else if (blinkHide) begin
            dot = 1'b0;
        end else begin
            dot = glyphDot;
        end
        idxNext = dot ? fg : bg;
    end

    // Stage 1 register; sync resets to its idle level so no spurious pulse leaves the pipe.
    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            s1IdxR   <= 4'd0;
            s1BlankR <= 1'b0;
            s1HsR    <= 1'b1;
            s1VsR    <= 1'b0;
        end else begin
            s1IdxR   <= idxNext;
            s1BlankR <= iBlank;
            s1HsR    <= iHs;
            s1VsR    <= iVs;
        end
    end

    // Stage 2 RGBI map with brown fix-up; video enable acts here undelayed.
    always_comb begin
        rNext = 4'h0;
        gNext = 4'h0;
        bNext = 4'h0;
        if (s1BlankR || !iVideoEn) begin
            rNext = 4'h0;
            gNext = 4'h0;
            bNext = 4'h0;
        end else begin
            rNext = rgbiChan(s1IdxR[2], s1IdxR[3]);
            bNext = rgbiChan(s1IdxR[0], s1IdxR[3]);
            if (s1IdxR == 4'd6) begin
                gNext = 4'h5;
            end else begin
                gNext = rgbiChan(s1IdxR[1], s1IdxR[3]);
            end
        end
    end

    // Stage 2 output register driving the VGA pins.
    always_ff @(posedge iClk25 or negedge iRstN) begin
        if (!iRstN) begin
            oVgaR  <= 4'h0;
            oVgaG  <= 4'h0;
            oVgaB  <= 4'h0;
            oVgaHs <= 1'b1;
            oVgaVs <= 1'b0;
        end else begin
            oVgaR  <= rNext;
            oVgaG  <= gNext;
            oVgaB  <= bNext;
            oVgaHs <= s1HsR;
            oVgaVs <= s1VsR;
        end
    end

endmodule

// File: doc/video_cga_pixel.md
Name: video_cga_pixel

Overview:
Text-mode pixel back end for the CGA adapter. It sits directly downstream of the VRAM read port and font ROM lookup. It takes the per-dot character, attribute and glyph row, plus the CRTC position and sync signals, all already aligned. It applies attribute colour, character blink and hardware cursor, maps 4-bit RGBI to 12-bit VGA, and drives the registered VGA pins with fixed latency.

Parameters:
BLINK_BIT, 4, frame-counter bit that gives character blink phase (16 frames on, 16 frames off).
CURSOR_BIT, 3, frame-counter bit that gives cursor blink phase (8 frames on, 8 frames off).

Ports:
iClk25  in  1  VGA pixel clock; the only clock.
iRstN  in  1  asynchronous, active-low reset.
iChar  in  8  character code of current cell (informational; not used in colour path).
iAttr  in  8  attribute byte of current cell.
iGlyphRow  in  8  font row for current cell and row; bit 7 is the leftmost dot.
iDA  in  4  dot address 0..15; each font bit spans 2 dots.
iRA  in  3  row address 0..7 within the glyph.
iCellAddr  in  12  character address of current cell.
iBlank  in  1  blanking, active high.
iHs  in  1  horizontal sync, active-low pulse.
iVs  in  1  vertical sync, active-high pulse.
iVideoEn  in  1  mode register video-enable bit.
iBlinkEn  in  1  mode register blink bit; 1 = attr[7] is blink, 0 = attr[7] is bright background.
iCursorAddr  in  12  cursor cell address.
iCursorStart  in  3  first cursor scan row.
iCursorEnd  in  3  last cursor scan row.
oVgaR  out  4  red.
oVgaG  out  4  green.
oVgaB  out  4  blue.
oVgaHs  out  1  delayed iHs.
oVgaVs  out  1  delayed iVs.

Behaviour:
- All inputs are sampled on iClk25 and belong to the same dot. Mode and cursor inputs are already synchronous to iClk25.
- Pipeline has 2 register stages. Every output, including sync, reflects the inputs sampled 2 cycles earlier. There is no stall.
- Reset: stage registers cleared; oVgaR/G/B = 0; oVgaHs = 1; oVgaVs = 0; frame counter = 0. Reset asserted mid-frame forces these values immediately.
- Frame counter: 5 bits; increments on each iVs rising edge (iVs high and previous-cycle iVs low); wraps 31 -> 0.
  - blinkPhase = cnt[BLINK_BIT]
  - cursorPhase = cnt[CURSOR_BIT]
- Stage 1:
  - dot = iGlyphRow[7 - iDA[3:1]].
  - fg = iAttr[3:0].
  - bg = iBlinkEn ? {1'b0, iAttr[6:4]} : iAttr[7:4].
  - blinkHide = iBlinkEn & iAttr[7] & blinkPhase; when set, dot is forced to 0.
  - cursorHit = (iCellAddr == iCursorAddr) & (iRA >= iCursorStart) & (iRA <= iCursorEnd) & cursorPhase. cursorHit forces dot to 1, and takes priority over blinkHide.
  - iCursorStart > iCursorEnd means no cursor.
  - idx = dot ? fg : bg.
  - Register idx, iBlank, iHs, iVs.
- Stage 2 (RGBI map, registered):
  - For each of R (idx[2]), G (idx[1]) and B (idx[0]): channel = bit ? (I ? F : A) : (I ? 5 : 0), where I = idx[3].
  - Exception: idx == 6 gives G = 5 (brown). idx == 14 is unaffected.
  - If delayed blank = 1 or iVideoEn = 0, RGB = 0.
  - Syncs always pass through, independent of iVideoEn.
- iVideoEn is applied at stage 2 without delay, so a change takes effect 1 cycle after sampling.
- A cell address match with iRA outside the start..end range produces no cursor.
- A simultaneous iVs edge and cursor or blink evaluation uses the counter value before the increment.

Optional Feature:
Macro: VIDEO_CGA_CURSOR_EN.
- Defined: hardware cursor as described above.
- Undefined: cursorHit is constant 0.
  - iCursorAddr, iCursorStart and iCursorEnd are ignored.
  - Counter bit CURSOR_BIT is still maintained.
  - Pipeline latency is unchanged.

Test Plan:
1. Reset: hold iRstN = 0 with random inputs -> oVgaR/G/B = 0, oVgaHs = 1, oVgaVs = 0. Release reset, drive iBlank = 0, iAttr = 0x1E, iGlyphRow = 0x80, iDA = 0 -> 2 cycles later RGB = (F,F,5) (yellow).
2. Colour map: sweep iAttr[3:0] 0..15 with iGlyphRow = 0xFF -> outputs match the RGBI table; idx 6 gives (A,5,0); idx 8 gives (5,5,5); idx 15 gives (F,F,F).
3. Bit order: iGlyphRow = 0x01, sweep iDA 0..15 -> only iDA = 14 and 15 show fg, each appearing 2 cycles after input.
4. Blink: iBlinkEn = 1, iAttr = 0x9F, iGlyphRow = 0xFF, pulse iVs 16 times -> fg white, then blue bg (0,0,A). With iBlinkEn = 0 the same attribute gives constant fg white, with bg (5,5,F) wherever dot = 0.
5. Cursor: iCursorAddr = 0x123, start 6, end 7, iGlyphRow = 0 -> fg shown only at iCellAddr = 0x123 and iRA 6..7, in frames 8..15 mod 16. Start 7 with end 6 -> never shown.
6. Blank, video-enable and sync: iBlank = 1 or iVideoEn = 0 -> RGB = 0 while iHs/iVs toggles appear on oVgaHs/oVgaVs exactly 2 cycles later.
